// File: rtl/pps_gen_multi.sv
`default_nettype none
// ============================================================================
//  Module   : pps_gen_multi
//  Purpose  : Programmable PPS epoch generator with NUM_PULSE shaped pulse
//             outputs, NUM_EM event-mark timestampers and a CPU counter latch,
//             attached to the gnss_top host register bus.
//  Revision : 1.0  initial release
// ============================================================================
module pps_gen_multi #(
    parameter int CNT_W     = 31,
    parameter int DELAY_W   = 16,
    parameter int WIDTH_W   = 30,
    parameter int PCNT_W    = 8,
    parameter int NUM_PULSE = 4,
    parameter int NUM_EM    = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 host_cs,
    input  logic                 host_rd,
    input  logic                 host_wr,
    input  logic [5:0]           host_addr,
    input  logic [31:0]          host_d4wt,
    output logic [31:0]          host_d4rd,
    input  logic                 cpu_latch,
    input  logic [NUM_EM-1:0]    event_mark,
    output logic [NUM_PULSE-1:0] pps_pulse,
    output logic                 pps_event,
    output logic                 pps_irq,
    output logic                 em_irq
);

    localparam logic [5:0] c_ADDR_CTRL        = 6'h00;
    localparam logic [5:0] c_ADDR_INTERVAL    = 6'h01;
    localparam logic [5:0] c_ADDR_ADJUST      = 6'h02;
    localparam logic [5:0] c_ADDR_STATUS      = 6'h03;
    localparam logic [5:0] c_ADDR_CLK_LATCH   = 6'h04;
    localparam logic [5:0] c_ADDR_PULSE_LATCH = 6'h05;
    localparam logic [5:0] c_EVT_HOLD         = 6'd32;

    logic                    w_wr;
    logic                    r_pps_en, r_int_en, r_em_int_en;
    logic [CNT_W-2:0]        r_interval, r_adjust;
    logic [CNT_W-1:0]        r_clk_cnt, r_clk_latch;
    logic [PCNT_W-1:0]       r_pulse_cnt, r_pulse_latch;
    logic [5:0]              r_evt_cnt;
    logic signed [CNT_W:0]   w_target;
    logic [CNT_W:0]          w_target_pos;
    logic                    w_epoch;
    logic [NUM_PULSE-1:0][31:0] w_pctrl_rd, w_pwid_rd;
    logic [NUM_EM-1:0]       w_em_valid, w_em_ovf;
    logic [NUM_EM-1:0][1:0]  w_em_edge;
    logic [NUM_EM-1:0][CNT_W-1:0]  w_em_clk;
    logic [NUM_EM-1:0][PCNT_W-1:0] w_em_pulse;
    logic [31:0]             w_status;
    logic                    w_unused;

    assign w_wr     = host_cs & host_wr;
    assign w_unused = ^{host_rd, host_d4wt};

    // Period target: INTERVAL plus signed one-shot ADJUST, clamped to at least 1.
    // INTERVAL counts the cycles after the epoch cycle, so a period spans target+1 clocks;
    // the >= test makes a late negative adjust fire at once instead of running away.
    assign w_target     = $signed({2'b00, r_interval}) + $signed({{2{r_adjust[CNT_W-2]}}, r_adjust});
    assign w_target_pos = (w_target[CNT_W] || (w_target == '0)) ? (CNT_W+1)'(1) : w_target;
    assign w_epoch      = r_pps_en && ({1'b0, r_clk_cnt} >= w_target_pos);

    assign pps_event = (r_evt_cnt != '0);
    assign pps_irq   = pps_event & r_int_en;
    assign em_irq    = (|w_em_valid) & r_em_int_en;
    assign w_status  = {8'h00, 8'(w_em_ovf), 8'(w_em_valid), 8'h00};

    // Global control registers, epoch counters, event hold timer and CPU latch.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pps_en      <= 1'b0;
            r_int_en      <= 1'b0;
            r_em_int_en   <= 1'b0;
            r_interval    <= '0;
            r_adjust      <= '0;
            r_clk_cnt     <= '0;
            r_pulse_cnt   <= '0;
            r_evt_cnt     <= '0;
            r_clk_latch   <= '0;
            r_pulse_latch <= '0;
        end else begin
            if (w_wr && host_addr == c_ADDR_CTRL) begin
                r_pps_en    <= host_d4wt[0];
                r_int_en    <= host_d4wt[1];
                r_em_int_en <= host_d4wt[2];
            end
            if (w_wr && host_addr == c_ADDR_INTERVAL)
                r_interval <= host_d4wt[CNT_W-2:0];
            // A host write in the epoch cycle survives and applies to the next period.
            if (w_wr && host_addr == c_ADDR_ADJUST)
                r_adjust <= host_d4wt[CNT_W-2:0];
            else if (w_epoch)
                r_adjust <= '0;
            if (w_epoch) begin
                r_clk_cnt   <= '0;
                r_pulse_cnt <= r_pulse_cnt + PCNT_W'(1);
            end else if (r_pps_en) begin
                r_clk_cnt   <= r_clk_cnt + CNT_W'(1);
            end
            if (w_epoch)
                r_evt_cnt <= c_EVT_HOLD;
            else if (r_evt_cnt != '0)
                r_evt_cnt <= r_evt_cnt - 6'd1;
            if (cpu_latch) begin
                r_clk_latch   <= r_clk_cnt;
                r_pulse_latch <= r_pulse_cnt;
            end
        end
    end

    generate
        for (genvar i = 0; i < NUM_PULSE; i++) begin : g_pulse
            localparam logic [5:0] c_ADDR_PCTRL = 6'(8 + 2*i);
            localparam logic [5:0] c_ADDR_PWID  = 6'(9 + 2*i);
            logic [DELAY_W-1:0] r_delay, r_dcnt;
            logic [WIDTH_W-1:0] r_width, r_wcnt;
            logic [3:0]         r_div, r_div_cnt;
            logic               r_en, r_pol, r_pend, r_high;
            logic               w_sel_ctrl, w_fire;
            logic [WIDTH_W-1:0] w_wload;

            assign w_sel_ctrl = w_wr && (host_addr == c_ADDR_PCTRL);
            assign w_fire     = w_epoch && (r_div_cnt == r_div);
            assign w_wload    = (r_width == '0) ? WIDTH_W'(1) : r_width;

            // Channel config, epoch divider, and delay/width shaping of the pulse.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_delay <= '0; r_en <= 1'b0; r_pol <= 1'b0; r_div <= '0;
                    r_width <= '0; r_div_cnt <= '0;
                    r_pend  <= 1'b0; r_dcnt <= '0; r_high <= 1'b0; r_wcnt <= '0;
                end else begin
                    if (w_sel_ctrl) begin
                        r_delay <= host_d4wt[DELAY_W-1:0];
                        r_en    <= host_d4wt[16];
                        r_pol   <= host_d4wt[17];
                        r_div   <= host_d4wt[23:20];
                    end
                    if (w_wr && host_addr == c_ADDR_PWID)
                        r_width <= host_d4wt[WIDTH_W-1:0];
                    if (w_sel_ctrl)
                        r_div_cnt <= '0;
                    else if (w_epoch)
                        r_div_cnt <= w_fire ? 4'd0 : r_div_cnt + 4'd1;
                    if (w_fire) begin
                        // Already high or no delay: (re)start the width now; else restart the delay.
                        if (r_high || r_delay == '0) begin
                            r_high <= 1'b1;
                            r_wcnt <= w_wload;
                            r_pend <= 1'b0;
                        end else begin
                            r_pend <= 1'b1;
                            r_dcnt <= r_delay;
                        end
                    end else begin
                        if (r_pend) begin
                            if (r_dcnt == DELAY_W'(1)) begin
                                r_pend <= 1'b0;
                                r_high <= 1'b1;
                                r_wcnt <= w_wload;
                            end else begin
                                r_dcnt <= r_dcnt - DELAY_W'(1);
                            end
                        end
                        if (r_high) begin
                            if (r_wcnt == WIDTH_W'(1))
                                r_high <= 1'b0;
                            else
                                r_wcnt <= r_wcnt - WIDTH_W'(1);
                        end
                    end
                end
            end

            assign pps_pulse[i]  = (r_high & r_en) ^ r_pol;
            assign w_pctrl_rd[i] = {8'h00, r_div, 2'b00, r_pol, r_en, 16'(r_delay)};
            assign w_pwid_rd[i]  = 32'(r_width);
        end

        for (genvar j = 0; j < NUM_EM; j++) begin : g_em
            localparam logic [5:0] c_ADDR_ECTRL = 6'(24 + 4*j);
            logic              r_s1, r_s2, r_prev, r_valid, r_ovf;
            logic [1:0]        r_edge;
            logic [CNT_W-1:0]  r_em_clk;
            logic [PCNT_W-1:0] r_em_pulse;
            logic              w_det, w_clr_v, w_clr_o;

            // Edge history always follows the synchroniser, so re-enabling never sees a stale edge.
            assign w_det   = (r_edge[0] & r_s2 & ~r_prev) | (r_edge[1] & ~r_s2 & r_prev);
            assign w_clr_v = w_wr && (host_addr == c_ADDR_STATUS) && host_d4wt[8+j];
            assign w_clr_o = w_wr && (host_addr == c_ADDR_STATUS) && host_d4wt[16+j];

            // Synchronise, detect edges, timestamp the first edge and flag any further ones.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_s1 <= 1'b0; r_s2 <= 1'b0; r_prev <= 1'b0;
                    r_edge <= '0; r_valid <= 1'b0; r_ovf <= 1'b0;
                    r_em_clk <= '0; r_em_pulse <= '0;
                end else begin
                    r_s1   <= event_mark[j];
                    r_s2   <= r_s1;
                    r_prev <= r_s2;
                    if (w_wr && host_addr == c_ADDR_ECTRL)
                        r_edge <= host_d4wt[1:0];
                    if (w_clr_v) r_valid <= 1'b0;
                    if (w_clr_o) r_ovf   <= 1'b0;
                    // A capture coincident with a clear wins and leaves valid set.
                    if (w_det) begin
                        if (!r_valid || w_clr_v) begin
                            r_em_clk   <= r_clk_cnt;
                            r_em_pulse <= r_pulse_cnt;
                            r_valid    <= 1'b1;
                        end else begin
                            r_ovf <= 1'b1;
                        end
                    end
                end
            end

            assign w_em_valid[j] = r_valid;
            assign w_em_ovf[j]   = r_ovf;
            assign w_em_edge[j]  = r_edge;
            assign w_em_clk[j]   = r_em_clk;
            assign w_em_pulse[j] = r_em_pulse;
        end
    endgenerate

    // Combinational read mux; unmapped addresses return zero.
    always_comb begin
        host_d4rd = '0;
        case (host_addr)
            c_ADDR_CTRL:        host_d4rd = {29'd0, r_em_int_en, r_int_en, r_pps_en};
            c_ADDR_INTERVAL:    host_d4rd = 32'(r_interval);
            c_ADDR_ADJUST:      host_d4rd = 32'(r_adjust);
            c_ADDR_STATUS:      host_d4rd = w_status;
            c_ADDR_CLK_LATCH:   host_d4rd = 32'(r_clk_latch);
            c_ADDR_PULSE_LATCH: host_d4rd = 32'(r_pulse_latch);
            default:            host_d4rd = '0;
        endcase
        for (int i = 0; i < NUM_PULSE; i++) begin
            if (host_addr == 6'(8 + 2*i)) host_d4rd = w_pctrl_rd[i];
            if (host_addr == 6'(9 + 2*i)) host_d4rd = w_pwid_rd[i];
        end
        for (int j = 0; j < NUM_EM; j++) begin
            if (host_addr == 6'(24 + 4*j)) host_d4rd = {30'd0, w_em_edge[j]};
            if (host_addr == 6'(25 + 4*j)) host_d4rd = 32'(w_em_clk[j]);
            if (host_addr == 6'(26 + 4*j)) host_d4rd = 32'(w_em_pulse[j]);
        end
    end

endmodule
`default_nettype wire
